instruction_fetch_unit: RTL and testbench

Initiator side of the instruction-memory read interface. Drives the word address into the combinational instruction memory, captures each returned instruction with its byte PC into a small prefetch FIFO, and hands them to decode over a valid/ready handshake. Also handles branch redirects and end-of-program detection (`Exit`). Sits between the PC/branch logic and the decode stage.

---
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: drives the word address into a combinational
// instruction memory and queues {pc, instr} pairs in a small prefetch FIFO.
// Decode takes them over a valid/ready handshake. A redirect flushes the
// FIFO and restarts fetch at a new PC.
// Optional feature macro: FETCH_HALT_ON_ZERO_EN. When it is defined, an
// all-zero instruction word ends the program (HALT), and Exit rises once
// the FIFO has drained.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          DEPTH     = 2,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Instruction_Add,
  input  logic [31:0] Instruction,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        Exit
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          AW      = $clog2(MEM_WORDS);
  localparam logic [31:0] WRAP_PC = 32'(MEM_WORDS * 4);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t         state;
  logic [31:0]    pc;
  fetch_entry_t   fifo [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count, count_nx;
  logic           exit_r;
  logic           pop, can_push, zero_hit, push;
  logic [31:0]    pc_inc, pc_seq;
  fetch_entry_t   head;

  // The two low bits of the redirect target are dropped to word-align it.
  logic unused_rpc_lsbs;
  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  assign Instruction_Add = 32'(pc[AW+1:2]);
  assign inst_valid      = (count != '0);
  assign head            = fifo[rd_ptr];
  assign inst_out        = inst_valid ? head.instr : 32'd0;
  assign pc_out          = inst_valid ? head.pc    : 32'd0;
  assign Exit            = exit_r;

  assign pop      = inst_valid && inst_ready;
  // A slot is available if the FIFO has room or the head leaves this cycle.
  assign can_push = (state == RUN) && ((count < CW'(DEPTH)) || pop);
`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_hit = can_push && (Instruction == 32'd0);
`else
  assign zero_hit = 1'b0;
`endif
  assign push     = can_push && !zero_hit;

  assign pc_inc = pc + 32'd4;
  assign pc_seq = (pc_inc == WRAP_PC) ? 32'd0 : pc_inc;

  // Occupancy after this cycle's push/pop (simultaneous ones cancel).
  always_comb begin
    count_nx = count;
    if (push && !pop)      count_nx = count + CW'(1);
    else if (!push && pop) count_nx = count - CW'(1);
  end

  // FIFO payload storage; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && !redirect && push) fifo[wr_ptr] <= '{pc: pc, instr: Instruction};
  end

  // PC, FIFO pointers, RUN/HALT state and the registered Exit flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= RUN;
      exit_r <= 1'b0;
    end else if (redirect) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= RUN;
      exit_r <= 1'b0;
    end else begin
      if (push) begin
        pc     <= pc_seq;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_nx;
      if (zero_hit) state <= HALT;
      // Exit only once already halted and the last queued entry is gone.
      exit_r <= (state == HALT) && (count_nx == '0);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a directed vector table, a few
// hand-written multi-cycle sequences, then random traffic compared every
// cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
  localparam int          DEPTH = 2;
  localparam int          MW    = 32;
  localparam logic [31:0] RPC   = 32'd8;
`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, inst_ready, redirect, inst_valid, Exit;
  logic [31:0] Instruction_Add, Instruction, inst_out, pc_out, redirect_pc;
  logic [31:0] mem     [MW];
  logic [31:0] def_mem [MW];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign Instruction = mem[Instruction_Add[4:0]];

  instruction_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH), .MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .Instruction_Add(Instruction_Add),
    .Instruction(Instruction), .inst_out(inst_out), .pc_out(pc_out),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .Exit(Exit)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc   = 32'd0;
  bit          m_halt = 1'b0;
  bit          m_exit = 1'b0;
  bit          chk_en = 1'b0;

  // The model: a queue of fetched words, a PC and a halted flag.
  always @(posedge clk) begin : model
    bit          pop, was_halt;
    logic [31:0] w;
    if (reset) begin
      m_pc = RPC; mq.delete(); m_halt = 1'b0; m_exit = 1'b0;
    end else if (redirect) begin
      m_pc = redirect_pc & ~32'd3; mq.delete(); m_halt = 1'b0; m_exit = 1'b0;
    end else begin
      pop      = (mq.size() > 0) && inst_ready;
      w        = mem[(m_pc >> 2) % MW];
      was_halt = m_halt;
      if (pop) void'(mq.pop_front());
      if (!m_halt && mq.size() < DEPTH) begin
        if (HALT_EN && w == 32'd0) m_halt = 1'b1;
        else begin
          mq.push_back('{pc: m_pc, ins: w});
          m_pc = (m_pc + 32'd4 == MW * 4) ? 32'd0 : m_pc + 32'd4;
        end
      end
      m_exit = was_halt && (mq.size() == 0);
    end
  end

  // Lockstep comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("lk_add", Instruction_Add, (m_pc >> 2) % MW);
      chk("lk_vld", {31'd0, inst_valid}, {31'd0, mq.size() > 0});
      chk("lk_pc",  pc_out,   (mq.size() > 0) ? mq[0].pc  : 32'd0);
      chk("lk_ins", inst_out, (mq.size() > 0) ? mq[0].ins : 32'd0);
      chk("lk_exit", {31'd0, Exit}, {31'd0, m_exit});
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          rst, rdy;
    logic [31:0] e_add, e_pc, e_ins;
    bit          e_vld, e_exit;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mkv(bit rst, bit rdy, logic [31:0] a, bit v,
                               logic [31:0] p, logic [31:0] i, bit x);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.e_add = a; r.e_vld = v;
    r.e_pc = p; r.e_ins = i; r.e_exit = x;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exp_out(string nm, logic [31:0] a, bit v, logic [31:0] p,
                         logic [31:0] i, bit x);
    chk({nm, "_add"}, Instruction_Add, a);
    chk({nm, "_vld"}, {31'd0, inst_valid}, {31'd0, v});
    chk({nm, "_pc"},  pc_out, p);
    chk({nm, "_ins"}, inst_out, i);
    chk({nm, "_exit"}, {31'd0, Exit}, {31'd0, x});
  endtask

  initial begin
    for (int i = 0; i < MW; i++) def_mem[i] = 32'd0;
    for (int i = 3; i <= 9; i++) def_mem[i] = 32'h1000_0000 | i;
    def_mem[2]  = 32'h0070_0113;
    def_mem[5]  = 32'h0000_8133;
    def_mem[10] = 32'h0320_0093;
    for (int i = 0; i < MW; i++) mem[i] = def_mem[i];

    // Scenario 1 vector table: reset row, nine streaming beats, tail rows.
    tbl[0] = mkv(1, 1, 2, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++)
      tbl[k] = mkv(0, 1, 32'(2 + k), 1, 32'(4 + 4 * k), def_mem[1 + k], 0);
    if (HALT_EN) begin
      tbl[10] = mkv(0, 1, 11, 0, 0, 0, 0);
      tbl[11] = mkv(0, 1, 11, 0, 0, 0, 1);
    end else begin
      tbl[10] = mkv(0, 1, 12, 1, 32'h2C, 0, 0);
      tbl[11] = mkv(0, 1, 13, 1, 32'h30, 0, 0);
    end

    reset = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
    @(negedge clk);
    chk_en = 1'b1;

    for (int r = 0; r < 12; r++) begin
      reset = tbl[r].rst; inst_ready = tbl[r].rdy;
      cyc();
      exp_out($sformatf("s1_r%0d", r), tbl[r].e_add, tbl[r].e_vld,
              tbl[r].e_pc, tbl[r].e_ins, tbl[r].e_exit);
    end

    // Scenario 2: backpressure then release.
    reset = 1'b1; inst_ready = 1'b0;
    cyc();
    exp_out("s2_rst", 2, 0, 0, 0, 0);
    reset = 1'b0;
    cyc();
    exp_out("s2_c1", 3, 1, 8, 32'h0070_0113, 0);
    for (int c = 2; c <= 5; c++) begin
      cyc();
      exp_out($sformatf("s2_c%0d", c), 4, 1, 8, 32'h0070_0113, 0);
    end
    inst_ready = 1'b1;
    cyc();
    exp_out("s2_b1", 5, 1, 32'h0C, def_mem[3], 0);
    cyc();
    exp_out("s2_b2", 6, 1, 32'h10, def_mem[4], 0);

    // Scenario 3: redirect while the FIFO is full.
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h16;
    cyc();
    exp_out("s3_r0", 5, 0, 0, 0, 0);
    redirect = 1'b0;
    cyc();
    exp_out("s3_r1", 6, 1, 32'h14, 32'h0000_8133, 0);

    // Scenario 4: wrap at the top of memory, halt on word0, redirect out.
    mem[31] = 32'h0000_0013;
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h7C;
    cyc();
    exp_out("s4_rd", 31, 0, 0, 0, 0);
    redirect = 1'b0;
    cyc();
    exp_out("s4_top", 0, 1, 32'h7C, 32'h13, 0);
    cyc();
    if (HALT_EN) exp_out("s4_h0", 0, 0, 0, 0, 0);
    else         exp_out("s4_h0", 1, 1, 0, 0, 0);
    cyc();
    chk("s4_exit", {31'd0, Exit}, {31'd0, HALT_EN});
    redirect = 1'b1; redirect_pc = 32'h08;
    cyc();
    exp_out("s4_rd8", 2, 0, 0, 0, 0);
    redirect = 1'b0;
    cyc();
    exp_out("s4_run", 3, 1, 8, 32'h0070_0113, 0);

    // Scenario 5: reset while Exit is high (halt build) or while streaming.
    redirect = 1'b1; redirect_pc = 32'h0;
    cyc();
    redirect = 1'b0;
    cyc();
    cyc();
    chk("s5_exit_hi", {31'd0, Exit}, {31'd0, HALT_EN});
    reset = 1'b1;
    cyc();
    exp_out("s5_rst", 2, 0, 0, 0, 0);
    reset = 1'b0;

    // Random traffic; the lockstep block does the checking.
    for (int i = 0; i < MW; i++)
      mem[i] = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
    for (int n = 0; n < 3000; n++) begin
      inst_ready  = ($urandom_range(3) != 0);
      redirect    = ($urandom_range(19) == 0);
      redirect_pc = $urandom_range(1) ? 32'($urandom_range(127)) : $urandom;
      reset       = ($urandom_range(199) == 0);
      if ($urandom_range(15) == 0)
        mem[$urandom_range(MW - 1)] = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      cyc();
    end
    reset = 1'b0; redirect = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
